// File: rtl/avm_cmd_master.sv
// Avalon-MM single-command master: turns a valid/ready command into one
// bus read or write and returns a valid/ready response.
// Ports: clk, reset (async, active-high);
//        cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata (command in);
//        rsp_valid/rsp_ready/rsp_rdata/rsp_error (response out);
//        avm_* (Avalon-MM master, zero read latency, waitrequest stall).
module avm_cmd_master #(
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic              avm_read_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_t;

    // Counter value at which one more stalled edge reaches TIMEOUT.
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] stall_cnt;

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            stall_cnt      <= '0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_read_n     <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_error      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        avm_address    <= cmd_addr;
                        avm_chipselect <= 1'b1;
                        stall_cnt      <= '0;
                        if (cmd_write) begin
                            avm_writedata <= cmd_wdata;
                            avm_write_n   <= 1'b0;
                            state         <= WRITE;
                        end else begin
                            avm_read_n <= 1'b0;
                            state      <= READ;
                        end
                    end
                end
                WRITE, READ: begin
                    // Completion is tested first so that a slave releasing
                    // waitrequest on the last allowed cycle still wins.
                    if (!avm_waitrequest) begin
                        avm_chipselect <= 1'b0;
                        avm_write_n    <= 1'b1;
                        avm_read_n     <= 1'b1;
                        rsp_valid      <= 1'b1;
                        rsp_error      <= 1'b0;
                        rsp_rdata      <= (state == READ) ? avm_readdata : '0;
                        state          <= RESP;
                    end else if (stall_cnt == STALL_LAST) begin
                        stall_cnt      <= stall_cnt + 16'd1;
                        avm_chipselect <= 1'b0;
                        avm_write_n    <= 1'b1;
                        avm_read_n     <= 1'b1;
                        rsp_valid      <= 1'b1;
                        rsp_error      <= 1'b1;
                        rsp_rdata      <= '0;
                        state          <= RESP;
                    end else begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
